// File: rtl/vid_pkg.sv
// Shared timing defaults, word constants and raster-size helpers for the video
// serializer and its timing generator.
package vid_pkg;

    localparam int WORD_W = 32;

    localparam int DEF_H_ACTIVE = 1024;
    localparam int DEF_H_FP     = 24;
    localparam int DEF_H_SYNC   = 136;
    localparam int DEF_H_BP     = 160;
    localparam int DEF_V_ACTIVE = 768;
    localparam int DEF_V_FP     = 3;
    localparam int DEF_V_SYNC   = 6;
    localparam int DEF_V_BP     = 29;

    localparam logic [WORD_W-1:0] UNDERRUN_WORD = 32'h0;

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vid_timing.sv
// Raster counters with registered de/hsync/vsync/vblank_start and a
// combinational load request at every 32nd active pixel.
module vid_timing
    import vid_pkg::*;
#(
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    output logic active,
    output logic load_req,
    output logic de,
    output logic hsync,
    output logic vsync,
    output logic vblank_start
);

    localparam int HT = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int VT = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW = $clog2(HT);
    localparam int VW = $clog2(VT);

    // Inclusive upper bounds keep every constant inside the counter width.
    localparam logic [HW-1:0] H_LAST      = HW'(HT - 1);
    localparam logic [HW-1:0] H_ACT_LAST  = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] HS_FIRST    = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_LAST     = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST      = VW'(VT - 1);
    localparam logic [VW-1:0] V_ACT_LAST  = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] VS_FIRST    = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_LAST     = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [VW-1:0] VBLANK_LINE = VW'(V_ACTIVE);

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          h_in_sync;
    logic          v_in_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == H_LAST) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
        end else begin
            hcnt <= hcnt + 1'b1;
        end
    end

    assign active    = (hcnt <= H_ACT_LAST) && (vcnt <= V_ACT_LAST);
    assign load_req  = active && (hcnt[4:0] == 5'd0);
    assign h_in_sync = (hcnt >= HS_FIRST) && (hcnt <= HS_LAST);
    assign v_in_sync = (vcnt >= VS_FIRST) && (vcnt <= VS_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de           <= 1'b0;
            hsync        <= ~HSYNC_POL;
            vsync        <= ~VSYNC_POL;
            vblank_start <= 1'b0;
        end else begin
            de           <= active;
            hsync        <= h_in_sync ? HSYNC_POL : ~HSYNC_POL;
            vsync        <= v_in_sync ? VSYNC_POL : ~VSYNC_POL;
            vblank_start <= (hcnt == '0) && (vcnt == VBLANK_LINE);
        end
    end

endmodule

// File: rtl/vid_serializer.sv
// Pops one 32-bit word per 32 active pixels and shifts it out LSB first,
// substituting a blank word and flagging underrun when the queue is empty.
module vid_serializer
    import vid_pkg::*;
#(
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] q,
    input  logic              empty,
    output logic              rd_en,
    output logic              pixel,
    output logic              de,
    output logic              hsync,
    output logic              vsync,
    output logic              vblank_start,
    output logic              underrun,
    input  logic              underrun_clr
);

    logic              active;
    logic              load_req;
    logic [WORD_W-1:0] word;
    logic [WORD_W-1:0] sr;

    vid_timing #(
        .H_ACTIVE  (H_ACTIVE),
        .H_FP      (H_FP),
        .H_SYNC    (H_SYNC),
        .H_BP      (H_BP),
        .V_ACTIVE  (V_ACTIVE),
        .V_FP      (V_FP),
        .V_SYNC    (V_SYNC),
        .V_BP      (V_BP),
        .HSYNC_POL (HSYNC_POL),
        .VSYNC_POL (VSYNC_POL)
    ) u_timing (
        .clk          (clk),
        .rst_n        (rst_n),
        .active       (active),
        .load_req     (load_req),
        .de           (de),
        .hsync        (hsync),
        .vsync        (vsync),
        .vblank_start (vblank_start)
    );

    // Counters sit at 0,0 (a load position) during reset, so gate the pop strobe.
    assign rd_en = load_req && !empty && rst_n;
    assign word  = empty ? UNDERRUN_WORD : q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr    <= '0;
            pixel <= 1'b0;
        end else if (load_req) begin
            pixel <= word[0];
            sr    <= {1'b0, word[WORD_W-1:1]};
        end else begin
            pixel <= active ? sr[0] : 1'b0;
            sr    <= {1'b0, sr[WORD_W-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun <= 1'b0;
        end else if (load_req && empty) begin
            underrun <= 1'b1;
        end else if (underrun_clr) begin
            underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vid_serializer.sv
// Directed bench for vid_serializer on a reduced 64x2 raster: timing, serialization,
// pop schedule, underrun substitution/stickiness and asynchronous reset.
module tb_vid_serializer;

    localparam int H_ACT = 64;
    localparam int H_TOT = 72;
    localparam int V_ACT = 2;
    localparam int V_TOT = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] q;
    logic        empty;
    logic        rd_en;
    logic        pixel;
    logic        de;
    logic        hsync;
    logic        vsync;
    logic        vblank_start;
    logic        underrun;
    logic        underrun_clr;

    int vecCnt  = 0;
    int missCnt = 0;

    int hC = 0;
    int vC = 0;
    int frameCnt = 0;
    int headIdx = 0;
    int popCnt = 0;
    int emptyCnt = 0;
    logic expUnder = 1'b0;
    logic [31:0] segWord = 32'h0;

    logic [31:0] words [16] = '{
        32'h0000_0001, 32'h8000_0000, 32'hA5A5_5A5A, 32'hFFFF_0000,
        32'hFFFF_FFFF, 32'h0000_0000, 32'h1234_5678, 32'h8000_0001,
        32'h0F0F_F0F0, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'h0000_FFFF,
        32'hC3C3_3C3C, 32'h7777_EEEE, 32'h0101_8080, 32'h5555_AAAA
    };

    vid_serializer #(
        .H_ACTIVE  (64),
        .H_FP      (2),
        .H_SYNC    (4),
        .H_BP      (2),
        .V_ACTIVE  (2),
        .V_FP      (1),
        .V_SYNC    (1),
        .V_BP      (1),
        .HSYNC_POL (1'b0),
        .VSYNC_POL (1'b0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .q            (q),
        .empty        (empty),
        .rd_en        (rd_en),
        .pixel        (pixel),
        .de           (de),
        .hsync        (hsync),
        .vsync        (vsync),
        .vblank_start (vblank_start),
        .underrun     (underrun),
        .underrun_clr (underrun_clr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCnt++;
        if (obs !== exp) begin
            missCnt++;
            $display("[TB] FAIL %s: got %0h, want %0h (h=%0d v=%0d frame=%0d t=%0t)",
                     tag, obs, exp, hC, vC, frameCnt, $time);
        end
    endtask

    function automatic logic isLoad(input int h, input int v);
        return (h < H_ACT) && (v < V_ACT) && (h % 32 == 0);
    endfunction

    task automatic checkResetValues(input string phase);
        checkOutput({phase, "_pixel"}, 32'(pixel), 32'(1'b0));
        checkOutput({phase, "_de"}, 32'(de), 32'(1'b0));
        checkOutput({phase, "_hsync"}, 32'(hsync), 32'(1'b1));
        checkOutput({phase, "_vsync"}, 32'(vsync), 32'(1'b1));
        checkOutput({phase, "_vblank"}, 32'(vblank_start), 32'(1'b0));
        checkOutput({phase, "_underrun"}, 32'(underrun), 32'(1'b0));
        checkOutput({phase, "_rd_en"}, 32'(rd_en), 32'(1'b0));
    endtask

    // Drive inputs for the counter state now in (hC,vC) and check the pop strobe.
    task automatic driveState();
        empty = ((frameCnt == 2 && vC == 0 && hC == 32) ||
                 (frameCnt == 5 && vC == 0 && hC == 0)) ? 1'b1 : 1'b0;
        underrun_clr = (frameCnt == 4 && vC == 0 && hC == 5) ? 1'b1 : 1'b0;
        q = words[headIdx % 16];
        if (isLoad(hC, vC)) begin
            segWord = empty ? 32'h0 : q;
            if (empty) emptyCnt++;
        end
        #1;
        checkOutput("rd_en", 32'(rd_en), 32'(isLoad(hC, vC) && !empty));
        if (rd_en === 1'b1) popCnt++;
    endtask

    // One clock: outputs registered from state (hC,vC), then advance the state.
    task automatic applyStimulus();
        logic expPix;
        @(negedge clk);
        if (isLoad(hC, vC) && empty) expUnder = 1'b1;
        else if (underrun_clr) expUnder = 1'b0;
        expPix = (hC < H_ACT && vC < V_ACT) ? segWord[hC % 32] : 1'b0;
        checkOutput("pixel", 32'(pixel), 32'(expPix));
        checkOutput("de", 32'(de), 32'(hC < H_ACT && vC < V_ACT));
        checkOutput("hsync", 32'(hsync), 32'(!(hC >= 66 && hC <= 69)));
        checkOutput("vsync", 32'(vsync), 32'(vC != 3));
        checkOutput("vblank_start", 32'(vblank_start), 32'(hC == 0 && vC == 2));
        checkOutput("underrun", 32'(underrun), 32'(expUnder));
        if (isLoad(hC, vC) && !empty) headIdx++;
        hC++;
        if (hC == H_TOT) begin
            hC = 0;
            vC++;
            if (vC == V_TOT) begin
                vC = 0;
                checkOutput("pops_per_frame", 32'(popCnt), 32'(4 - emptyCnt));
                popCnt = 0;
                emptyCnt = 0;
                frameCnt++;
            end
        end
        driveState();
    endtask

    task automatic enterReset();
        rst_n = 1'b0;
        #1;
        checkResetValues("reset_async");
        repeat (2) begin
            @(negedge clk);
            checkResetValues("reset_held");
        end
    endtask

    task automatic releaseReset(input int nextFrame);
        hC = 0;
        vC = 0;
        frameCnt = nextFrame;
        headIdx = 0;
        popCnt = 0;
        emptyCnt = 0;
        expUnder = 1'b0;
        rst_n = 1'b1;
        driveState();
    endtask

    initial begin
        int guard;
        rst_n = 1'b1;
        q = 32'h0;
        empty = 1'b0;
        underrun_clr = 1'b0;
        #2;
        enterReset();
        releaseReset(0);

        guard = 0;
        while (!(frameCnt == 5 && vC == 1 && hC == 20) && guard < 5000) begin
            applyStimulus();
            guard++;
        end
        checkOutput("reach_mid_reset_point", 32'(guard < 5000), 32'(1'b1));

        // Pixel and de are high here (word 4 = all ones, line 1) and underrun is set.
        #2;
        enterReset();
        releaseReset(6);
        repeat (H_TOT * V_TOT + 40) applyStimulus();

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
        $finish;
    end

endmodule
